// File: rtl/i2d_wb_arb_pkg.sv
// i2d_wb_arb_pkg: shared types for the i2d Wishbone arbiter.
// Holds the grant and state encodings, the master ids used by the
// round-robin history, and the request/response bundles.
package i2d_wb_arb_pkg;

  // Grant encodings as seen on gnt_o
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_F    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  // State values equal the grant encoding so gnt_o is the state register
  typedef enum logic [1:0] {
    ST_IDLE  = GNT_NONE,
    ST_GNT_F = GNT_F,
    ST_GNT_D = GNT_D
  } arb_state_e;

  // Master ids for the round-robin history bit
  localparam logic MST_F = 1'b0;
  localparam logic MST_D = 1'b1;

  // Master-to-slave bundle
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
  } wb_req_t;

  // Slave-to-master bundle
  typedef struct packed {
    logic [31:0] dat;
    logic        ack;
    logic        rty;
    logic        err;
  } wb_rsp_t;

  // Bus idle value: every field driven low
  function automatic wb_req_t wb_req_idle();
    wb_req_t r;
    r = '0;
    return r;
  endfunction

endpackage

// File: rtl/i2d_wb_arb_pick.sv
// i2d_wb_arb_pick: combinational arbitration between fetch and data.
// Ties go to D by default; with I2D_WB_ARB_RR_EN defined a tie goes to
// the master that did not hold the most recent grant.
import i2d_wb_arb_pkg::*;

module i2d_wb_arb_pick (
  input  logic       f_req,
  input  logic       d_req,
`ifdef I2D_WB_ARB_RR_EN
  input  logic       rr_last,
`endif
  output arb_state_e pick
);

  // Pick at most one requester; none requesting yields idle
  always_comb begin
    pick = ST_IDLE;
    if (f_req && d_req) begin
`ifdef I2D_WB_ARB_RR_EN
      pick = (rr_last == MST_D) ? ST_GNT_F : ST_GNT_D;
`else
      pick = ST_GNT_D;
`endif
    end else if (d_req) begin
      pick = ST_GNT_D;
    end else if (f_req) begin
      pick = ST_GNT_F;
    end
  end

endmodule

// File: rtl/i2d_wb_arb.sv
// i2d_wb_arb: two-master (fetch F, data D), one-slave Wishbone arbiter.
// Grant is registered; bus outputs are muxed combinationally from the
// owner. A waiting master sees rty while its cyc is high. The owner may
// complete MAX_HOLD transfers before it must hand over to a requesting
// peer, and handover only happens on a completed transfer or release.
// Optional: define I2D_WB_ARB_RR_EN for round-robin tie-breaking.
import i2d_wb_arb_pkg::*;

module i2d_wb_arb #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch master
  input  logic [31:0] f_adr_i,
  input  logic        f_cyc_i,
  input  logic        f_stb_i,
  output logic [31:0] f_dat_o,
  output logic        f_ack_o,
  output logic        f_rty_o,
  output logic        f_err_o,
  // data master
  input  logic [31:0] d_adr_i,
  input  logic [31:0] d_dat_i,
  input  logic [3:0]  d_sel_i,
  input  logic        d_we_i,
  input  logic        d_cyc_i,
  input  logic        d_stb_i,
  output logic [31:0] d_dat_o,
  output logic        d_ack_o,
  output logic        d_rty_o,
  output logic        d_err_o,
  // shared bus
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        rty_i,
  input  logic        err_i,
  output logic [1:0]  gnt_o
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_e state, state_nx, pick;
  logic [7:0] hold_cnt, hold_nx;
  logic       xfer, hold_last;
  wb_req_t    f_req, d_req, bus_req;
  wb_rsp_t    bus_rsp, f_rsp, d_rsp;
`ifdef I2D_WB_ARB_RR_EN
  logic       rr_last;
`endif

  // Pack master requests; fetch is always a full-word read
  always_comb begin
    f_req     = wb_req_idle();
    f_req.adr = f_adr_i;
    f_req.sel = 4'hF;
    f_req.cyc = f_cyc_i;
    f_req.stb = f_stb_i;
    d_req     = wb_req_idle();
    d_req.adr = d_adr_i;
    d_req.dat = d_dat_i;
    d_req.sel = d_sel_i;
    d_req.we  = d_we_i;
    d_req.cyc = d_cyc_i;
    d_req.stb = d_stb_i;
  end

  assign bus_rsp.dat = dat_i;
  assign bus_rsp.ack = ack_i;
  assign bus_rsp.rty = rty_i;
  assign bus_rsp.err = err_i;

  // Bus side: owner drives everything, idle drives zeros
  always_comb begin
    bus_req = wb_req_idle();
    case (state)
      ST_GNT_F: bus_req = f_req;
      ST_GNT_D: bus_req = d_req;
      default:  bus_req = wb_req_idle();
    endcase
  end

  assign adr_o = bus_req.adr;
  assign dat_o = bus_req.dat;
  assign sel_o = bus_req.sel;
  assign we_o  = bus_req.we;
  assign cyc_o = bus_req.cyc;
  assign stb_o = bus_req.stb;

  // Master side: owner sees the slave unchanged, others see retry while cyc
  always_comb begin
    f_rsp     = '0;
    f_rsp.rty = f_cyc_i;
    d_rsp     = '0;
    d_rsp.rty = d_cyc_i;
    if (state == ST_GNT_F) f_rsp = bus_rsp;
    if (state == ST_GNT_D) d_rsp = bus_rsp;
  end

  assign f_dat_o = f_rsp.dat;
  assign f_ack_o = f_rsp.ack;
  assign f_rty_o = f_rsp.rty;
  assign f_err_o = f_rsp.err;
  assign d_dat_o = d_rsp.dat;
  assign d_ack_o = d_rsp.ack;
  assign d_rty_o = d_rsp.rty;
  assign d_err_o = d_rsp.err;

  i2d_wb_arb_pick u_pick (
    .f_req   (f_cyc_i),
    .d_req   (d_cyc_i),
`ifdef I2D_WB_ARB_RR_EN
    .rr_last (rr_last),
`endif
    .pick    (pick)
  );

  // A completed transfer (ack or err, never rty) is the only handover point
  assign xfer      = ack_i | err_i;
  assign hold_last = (hold_cnt == HOLD_LAST);

  // Next grant and hold counter
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = pick;
      ST_GNT_F: begin
        if (!f_cyc_i)                           state_nx = pick;
        else if (d_cyc_i && xfer && hold_last)  state_nx = ST_GNT_D;
      end
      ST_GNT_D: begin
        if (!d_cyc_i)                           state_nx = pick;
        else if (f_cyc_i && xfer && hold_last)  state_nx = ST_GNT_F;
      end
      default: state_nx = ST_IDLE;
    endcase

    // Clear on any grant change; saturate while the peer stays quiet
    hold_nx = hold_cnt;
    if (state_nx != state || state_nx == ST_IDLE) hold_nx = '0;
    else if (xfer && !hold_last)                  hold_nx = hold_cnt + 8'd1;
  end

  // Grant, hold counter and round-robin history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
`ifdef I2D_WB_ARB_RR_EN
      rr_last  <= MST_F;
`endif
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
`ifdef I2D_WB_ARB_RR_EN
      if (state_nx == ST_GNT_F)      rr_last <= MST_F;
      else if (state_nx == ST_GNT_D) rr_last <= MST_D;
`endif
    end
  end

  assign gnt_o = state;

endmodule

// File: tb/tb_i2d_wb_arb.sv
// tb_i2d_wb_arb: directed checks of the i2d Wishbone arbiter (MAX_HOLD=4).
module tb_i2d_wb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_adr_i;
  logic        f_cyc_i, f_stb_i;
  logic [31:0] f_dat_o;
  logic        f_ack_o, f_rty_o, f_err_o;
  logic [31:0] d_adr_i, d_dat_i;
  logic [3:0]  d_sel_i;
  logic        d_we_i, d_cyc_i, d_stb_i;
  logic [31:0] d_dat_o;
  logic        d_ack_o, d_rty_o, d_err_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic        we_o, cyc_o, stb_o;
  logic [31:0] dat_i;
  logic        ack_i, rty_i, err_i;
  logic [1:0]  gnt_o;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  i2d_wb_arb #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .f_adr_i(f_adr_i), .f_cyc_i(f_cyc_i), .f_stb_i(f_stb_i),
    .f_dat_o(f_dat_o), .f_ack_o(f_ack_o), .f_rty_o(f_rty_o), .f_err_o(f_err_o),
    .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_sel_i(d_sel_i), .d_we_i(d_we_i),
    .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i),
    .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_rty_o(d_rty_o), .d_err_o(d_err_o),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .dat_i(dat_i), .ack_i(ack_i), .rty_i(rty_i), .err_i(err_i),
    .gnt_o(gnt_o)
  );

  // advance one edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    f_adr_i = '0; f_cyc_i = 0; f_stb_i = 0;
    d_adr_i = '0; d_dat_i = '0; d_sel_i = '0; d_we_i = 0; d_cyc_i = 0; d_stb_i = 0;
    dat_i = '0; ack_i = 0; rty_i = 0; err_i = 0;
    step(); step();
    rst = 1'b0;
    #1;
    tot_cnt++; if (gnt_o !== 2'b00) $display("FAIL reset_gnt got %h exp 0", gnt_o); else pass_cnt++;
    tot_cnt++; if (cyc_o !== 1'b0) $display("FAIL reset_cyc got %b exp 0", cyc_o); else pass_cnt++;
    tot_cnt++; if (adr_o !== 32'h0) $display("FAIL reset_adr got %h exp 0", adr_o); else pass_cnt++;
    tot_cnt++; if ({f_rty_o, d_rty_o} !== 2'b00) $display("FAIL reset_rty got %b exp 00", {f_rty_o, d_rty_o}); else pass_cnt++;
  endtask

  task automatic test_fetch_only();
    f_adr_i = 32'h100; f_cyc_i = 1; f_stb_i = 1;
    #1;
    tot_cnt++; if (gnt_o !== 2'b00) $display("FAIL f_req_idle_gnt got %h exp 0", gnt_o); else pass_cnt++;
    tot_cnt++; if (cyc_o !== 1'b0) $display("FAIL f_req_idle_cyc got %b exp 0", cyc_o); else pass_cnt++;
    tot_cnt++; if (f_rty_o !== 1'b1) $display("FAIL f_req_idle_rty got %b exp 1", f_rty_o); else pass_cnt++;
    step();
    tot_cnt++; if (gnt_o !== 2'b01) $display("FAIL f_gnt got %h exp 1", gnt_o); else pass_cnt++;
    tot_cnt++; if (adr_o !== 32'h100) $display("FAIL f_adr got %h exp 100", adr_o); else pass_cnt++;
    tot_cnt++; if ({cyc_o, stb_o, we_o, sel_o} !== 7'b110_1111) $display("FAIL f_bus_ctl got %b exp 1101111", {cyc_o, stb_o, we_o, sel_o}); else pass_cnt++;
    ack_i = 1; dat_i = 32'h1122_3344;
    #1;
    tot_cnt++; if (f_ack_o !== 1'b1) $display("FAIL f_ack got %b exp 1", f_ack_o); else pass_cnt++;
    tot_cnt++; if (f_dat_o !== 32'h1122_3344) $display("FAIL f_dat got %h exp 11223344", f_dat_o); else pass_cnt++;
    tot_cnt++; if ({d_rty_o, d_ack_o, d_dat_o} !== 34'h0) $display("FAIL f_d_quiet got %h exp 0", {d_rty_o, d_ack_o, d_dat_o}); else pass_cnt++;
    step();
    ack_i = 0; f_cyc_i = 0; f_stb_i = 0;
    step();
    tot_cnt++; if (gnt_o !== 2'b00) $display("FAIL f_release_gnt got %h exp 0", gnt_o); else pass_cnt++;
  endtask

  task automatic test_hold();
    f_adr_i = 32'h104; f_cyc_i = 1; f_stb_i = 1;
    step();
    d_adr_i = 32'h2000; d_dat_i = 32'hDEAD_BEEF; d_sel_i = 4'b0011; d_we_i = 1;
    d_cyc_i = 1; d_stb_i = 1;
    // fetch keeps its grant for exactly four acked transfers
    for (int i = 0; i < 4; i++) begin
      ack_i = 1;
      #1;
      tot_cnt++; if ({f_ack_o, d_rty_o} !== 2'b11) $display("FAIL hold_ack%0d got %b exp 11", i, {f_ack_o, d_rty_o}); else pass_cnt++;
      step();
      tot_cnt++; if (gnt_o !== ((i < 3) ? 2'b01 : 2'b10)) $display("FAIL hold_gnt%0d got %h exp %h", i, gnt_o, (i < 3) ? 2'b01 : 2'b10); else pass_cnt++;
    end
    ack_i = 0;
    #1;
    tot_cnt++; if ({we_o, sel_o} !== 5'b1_0011) $display("FAIL d_we_sel got %b exp 10011", {we_o, sel_o}); else pass_cnt++;
    tot_cnt++; if (dat_o !== 32'hDEAD_BEEF) $display("FAIL d_dat_o got %h exp deadbeef", dat_o); else pass_cnt++;
    tot_cnt++; if (adr_o !== 32'h2000) $display("FAIL d_adr got %h exp 2000", adr_o); else pass_cnt++;
    tot_cnt++; if (f_rty_o !== 1'b1) $display("FAIL f_rty_wait got %b exp 1", f_rty_o); else pass_cnt++;
    ack_i = 1; dat_i = 32'h0000_CAFE;
    #1;
    tot_cnt++; if (d_ack_o !== 1'b1) $display("FAIL d_ack got %b exp 1", d_ack_o); else pass_cnt++;
    tot_cnt++; if ({f_ack_o, f_dat_o} !== 33'h0) $display("FAIL f_masked got %h exp 0", {f_ack_o, f_dat_o}); else pass_cnt++;
    step();
    // data releases; fetch takes over without an idle cycle
    ack_i = 0; d_cyc_i = 0; d_stb_i = 0;
    #1;
    tot_cnt++; if (d_rty_o !== 1'b0) $display("FAIL d_rty_release got %b exp 0", d_rty_o); else pass_cnt++;
    step();
    tot_cnt++; if (gnt_o !== 2'b01) $display("FAIL direct_switch got %h exp 1", gnt_o); else pass_cnt++;
    // fresh hold window: four more fetch acks before data regains the bus
    d_we_i = 0; d_cyc_i = 1; d_stb_i = 1;
    for (int i = 0; i < 4; i++) begin
      ack_i = 1;
      step();
      tot_cnt++; if (gnt_o !== ((i < 3) ? 2'b01 : 2'b10)) $display("FAIL rehold_gnt%0d got %h exp %h", i, gnt_o, (i < 3) ? 2'b01 : 2'b10); else pass_cnt++;
    end
    ack_i = 0; f_cyc_i = 0; f_stb_i = 0; d_cyc_i = 0; d_stb_i = 0;
    step();
    tot_cnt++; if (gnt_o !== 2'b00) $display("FAIL hold_idle got %h exp 0", gnt_o); else pass_cnt++;
  endtask

  task automatic test_tie();
    logic [1:0] exp_gnt;
`ifdef I2D_WB_ARB_RR_EN
    exp_gnt = 2'b01;  // last grant was D
`else
    exp_gnt = 2'b10;
`endif
    f_cyc_i = 1; f_stb_i = 1; d_cyc_i = 1; d_stb_i = 1;
    step();
    tot_cnt++; if (gnt_o !== exp_gnt) $display("FAIL tie_gnt got %h exp %h", gnt_o, exp_gnt); else pass_cnt++;
    f_cyc_i = 0; f_stb_i = 0; d_cyc_i = 0; d_stb_i = 0;
    step();
    tot_cnt++; if (gnt_o !== 2'b00) $display("FAIL tie_idle got %h exp 0", gnt_o); else pass_cnt++;
  endtask

  task automatic test_retry();
    d_adr_i = 32'h3000; d_we_i = 0; d_sel_i = 4'hF; d_cyc_i = 1; d_stb_i = 1;
    step();
    tot_cnt++; if (gnt_o !== 2'b10) $display("FAIL rty_gnt got %h exp 2", gnt_o); else pass_cnt++;
    f_cyc_i = 1; f_stb_i = 1;
    for (int i = 0; i < 3; i++) begin
      rty_i = 1;
      #1;
      tot_cnt++; if ({d_rty_o, d_ack_o} !== 2'b10) $display("FAIL rty_mirror%0d got %b exp 10", i, {d_rty_o, d_ack_o}); else pass_cnt++;
      step();
    end
    rty_i = 0;
    // retries did not count: three acks keep D, the fourth completion hands over
    for (int i = 0; i < 3; i++) begin
      ack_i = 1;
      step();
      tot_cnt++; if (gnt_o !== 2'b10) $display("FAIL rty_nocount%0d got %h exp 2", i, gnt_o); else pass_cnt++;
    end
    ack_i = 0; err_i = 1;
    #1;
    tot_cnt++; if ({d_err_o, f_err_o} !== 2'b10) $display("FAIL err_route got %b exp 10", {d_err_o, f_err_o}); else pass_cnt++;
    step();
    err_i = 0;
    tot_cnt++; if (gnt_o !== 2'b01) $display("FAIL err_handover got %h exp 1", gnt_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    f_cyc_i = 0; f_stb_i = 0;
    step();
    tot_cnt++; if ({gnt_o, stb_o} !== 3'b101) $display("FAIL pre_rst got %b exp 101", {gnt_o, stb_o}); else pass_cnt++;
    f_cyc_i = 1; f_stb_i = 1; rst = 1; ack_i = 1;
    step();
    tot_cnt++; if (gnt_o !== 2'b00) $display("FAIL rst_mid_gnt got %h exp 0", gnt_o); else pass_cnt++;
    tot_cnt++; if ({cyc_o, stb_o} !== 2'b00) $display("FAIL rst_mid_cyc got %b exp 00", {cyc_o, stb_o}); else pass_cnt++;
    tot_cnt++; if ({f_ack_o, d_ack_o} !== 2'b00) $display("FAIL rst_mid_ack got %b exp 00", {f_ack_o, d_ack_o}); else pass_cnt++;
    f_cyc_i = 0; f_stb_i = 0; d_cyc_i = 0; d_stb_i = 0; ack_i = 0;
    #1;
    tot_cnt++; if ({f_rty_o, d_rty_o, f_err_o, d_err_o} !== 4'b0) $display("FAIL rst_mid_rty_err got %b exp 0000", {f_rty_o, d_rty_o, f_err_o, d_err_o}); else pass_cnt++;
    rst = 0;
    step();
    tot_cnt++; if (gnt_o !== 2'b00) $display("FAIL post_rst_gnt got %h exp 0", gnt_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_hold();
    test_tie();
    test_retry();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/i2d_wb_arb.md
Name:
i2d_wb_arb

Overview:
- Two-master, one-slave Wishbone arbiter for the i2d core.
- Shares the single external bus between the instruction fetch master (F) and the load/store data master (D).
- A non-granted requester is stalled with retry, which the fetch stage already treats as busy.
- Bounded hold time prevents the always-requesting fetch master from starving data accesses.

Parameters:
- MAX_HOLD, 4: acked transfers the owner may complete before forced handover when the other master is requesting (1..255).

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
f_adr_i  in  32  fetch address (fetch is always read, sel 4'b1111)
f_cyc_i  in  1  fetch cycle request
f_stb_i  in  1  fetch strobe
f_dat_o  out  32  read data to fetch
f_ack_o  out  1  fetch ack
f_rty_o  out  1  fetch retry/stall
f_err_o  out  1  fetch error
d_adr_i  in  32  data address
d_dat_i  in  32  data write data
d_sel_i  in  4  data byte selects
d_we_i  in  1  data write enable
d_cyc_i  in  1  data cycle request
d_stb_i  in  1  data strobe
d_dat_o  out  32  read data to data master
d_ack_o  out  1  data ack
d_rty_o  out  1  data retry/stall
d_err_o  out  1  data error
adr_o  out  32  bus address
dat_o  out  32  bus write data
sel_o  out  4  bus byte selects
we_o  out  1  bus write enable
cyc_o  out  1  bus cycle
stb_o  out  1  bus strobe
dat_i  in  32  bus read data
ack_i  in  1  bus ack
rty_i  in  1  bus retry
err_i  in  1  bus error
gnt_o  out  2  current grant: 00 none, 01 F, 10 D

Behaviour:
- States: IDLE, GNT_F, GNT_D; grant is registered. Reset: IDLE, hold_cnt=0, rr_last=F, gnt_o=00.
- IDLE: cyc_o=stb_o=we_o=0; adr_o, dat_o, sel_o = 0.
- GNT_x: all bus outputs come combinationally from master x. When owner is F: we_o=0, sel_o=4'hF, dat_o=0.
- Owner receives dat_i, ack_i, rty_i and err_i unchanged.
- Non-owner:
  - ack=0, err=0, dat=0.
  - rty=1 while its cyc is high, else 0.
  - rty stays 0 in every state when that master's cyc is low.
- Arbitration latency: one cycle. A request seen in IDLE is granted at the next edge, so the first bus cycle starts the cycle after the request.
- arb(): only one requester gets it. Both requesting gives D (fixed priority). Neither gives IDLE.
- Transitions from GNT_x:
  - Owner cyc low: next = arb(current requests). A direct switch to the other master is allowed, with no IDLE bubble.
  - Owner cyc high, other requesting, ack_i|err_i this cycle, hold_cnt==MAX_HOLD-1: switch to the other master.
  - Otherwise stay.
- Handover occurs only on a cycle that completed a transfer (ack_i/err_i) or on owner release. A bus cycle is never cut mid-transfer.
- hold_cnt (8-bit):
  - increments on each owner ack_i/err_i;
  - clears on any grant change or entry to IDLE;
  - saturates at MAX_HOLD-1 while the other master is not requesting.
- rty_i to the owner does not count toward hold_cnt.
- Reset asserted mid-transfer: next cycle is IDLE with cyc_o=0. No transfer is replayed.

Optional Feature:
- I2D_WB_ARB_RR_EN defined:
  - Simultaneous requests in arb() go to the master not recorded in rr_last.
  - rr_last updates on every grant to F or D.
- Undefined: D always wins ties and rr_last is absent.

Decomposition:
- i2d_core_defines.v gets `I2D_ARB_GNT_NONE/F/D encodings and the state encodings.
- One natural sub-module: i2d_arb_pick, combinational tie-break (fixed or round-robin) used by the FSM.

Test Plan:
- Reset, then F only requesting at 0x100: IDLE 1 cycle, then gnt_o=01, adr_o=0x100; acks reach f_ack_o; d_rty_o=0.
- F holds cyc continuously, D requests write 0xDEADBEEF to 0x2000 sel 4'b0011: after 4 F acks (MAX_HOLD=4) gnt_o=10 next cycle. Bus shows we_o=1, sel_o=0011, dat_o=0xDEADBEEF; f_rty_o=1 during D ownership.
- D releases cyc after ack while F requesting: next cycle gnt_o=01 with no IDLE cycle; hold_cnt=0.
- Both request from IDLE at the same cycle: default gives gnt_o=10. With I2D_WB_ARB_RR_EN and rr_last=D, gnt_o=01.
- Owner D gets rty_i for 3 cycles then ack: d_rty_o mirrors; no handover counted; err_i=1 goes only to d_err_o.
- rst=1 while GNT_D with stb_o high: next cycle cyc_o=0, gnt_o=00, all ack/rty/err outputs 0.
